// File: rtl/bitty_fetch_if.sv
// Instruction-memory and core handshake bundle for the bitty fetch unit.
// master = fetch unit; slave = memory plus core side.
interface bitty_fetch_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_en;
  logic [15:0]           mem_data;
  logic [15:0]           instruction;
  logic                  run;
  logic                  done;

  modport master (
    output mem_addr, mem_en, instruction, run,
    input  mem_data, done
  );

  modport slave (
    input  mem_addr, mem_en, instruction, run,
    output mem_data, done
  );
endinterface

// File: rtl/bitty_fetch_unit.sv
// Instruction sequencer for the bitty core: fetches from synchronous memory,
// issues each instruction with a run pulse and waits for done under a watchdog.
module bitty_fetch_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int PROG_LEN   = 16,
  parameter int LOOP       = 0,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  bitty_fetch_if.master         bus,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  halted,
  output logic                  error,
  output logic [15:0]           retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_MEM,
    S_ISSUE,
    S_EXEC,
    S_HALTED,
    S_ERROR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(PROG_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE  = ADDR_WIDTH'(1);
  localparam logic [15:0]           WD_LAST = 16'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]           instr_q, instr_d;
  logic [15:0]           retired_q, retired_d;
  logic [15:0]           wd_q, wd_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      mem_addr_q <= '0;
      instr_q    <= '0;
      retired_q  <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      instr_q    <= instr_d;
      retired_q  <= retired_d;
      wd_q       <= wd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    instr_d    = instr_q;
    retired_d  = retired_q;
    wd_d       = wd_q;

    unique case (state_q)
      S_IDLE, S_HALTED, S_ERROR: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          retired_d = '0;
        end
      end
      S_FETCH:    state_d = S_WAIT_MEM;
      S_WAIT_MEM: begin
        instr_d = bus.mem_data;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // done is checked before expiry so a completion on the last allowed cycle still retires
        if (bus.done) begin
          if (retired_q != '1) retired_d = retired_q + 16'd1;
          if (pc_q == LAST_PC) begin
            if (LOOP != 0) begin
              pc_d    = '0;
              state_d = S_FETCH;
            end else begin
              state_d = S_HALTED;
            end
          end else begin
            pc_d    = pc_q + PC_ONE;
            state_d = S_FETCH;
          end
        end else if (wd_q == WD_LAST) begin
          state_d = S_ERROR;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Address is registered on entry to FETCH so it holds between fetches.
    if (state_d == S_FETCH) mem_addr_d = pc_d;
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_en      = (state_q == S_FETCH);
  assign bus.instruction = instr_q;
  assign bus.run         = (state_q == S_ISSUE);

  assign pc      = pc_q;
  assign retired = retired_q;
  assign busy    = (state_q == S_FETCH) || (state_q == S_WAIT_MEM) ||
                   (state_q == S_ISSUE) || (state_q == S_EXEC);
  assign halted  = (state_q == S_HALTED);
  assign error   = (state_q == S_ERROR);

endmodule
